ex_muldiv_unit: RTL

- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline buffer.
- Consumes the buffered rs/rt operands and the decoded mul/div opcode. Produces the HI/LO results that the binomial-coefficient routines need for factorial products and quotients.
- Raises busy_o so hazard control can freeze the IF/ID and ID/EX buffers while an operation is iterating.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_iter_core.sv | 24 ++
 rtl/ex_muldiv_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package muldiv_pkg;
  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_t;
endpackage

// File: rtl/muldiv_iter_core.sv
// One radix-2 step over the {upper, lower} accumulator: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Remainder stays below the divisor, so bit WIDTH of trial is the borrow.
    trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (is_div)
      acc_nxt = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                             : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO access.
// Operates on magnitudes for WIDTH cycles, then applies signs in one fix-up cycle.
module ex_muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             wr_hi_i,
  input  logic             wr_lo_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o
);
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH-1:0]   opnd, rs_mag, rt_mag, quo, rem, fix_hi, fix_lo;
  logic               is_div, neg_q, neg_r, dz, op_div, op_sgn;

  assign op_div = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign op_sgn = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign rs_mag = (op_sgn && rs_i[WIDTH-1]) ? -rs_i : rs_i;
  assign rt_mag = (op_sgn && rt_i[WIDTH-1]) ? -rt_i : rt_i;

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div  (is_div),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_nxt)
  );

  // Divide by zero leaves |rs| in the remainder; re-signing it restores raw rs.
  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    fix_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    fix_lo = is_div ? (dz ? '1 : quo) : prod[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      is_div     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      dz         <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
      if (state != IDLE && flush_i) begin
        state  <= IDLE;
        cnt    <= '0;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (wr_hi_i) hi_o <= wdata_i;
            if (wr_lo_i) lo_o <= wdata_i;
            if (start_i && !flush_i) begin
              is_div <= op_div;
              neg_q  <= op_sgn && (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
              neg_r  <= op_sgn && rs_i[WIDTH-1];
              dz     <= op_div && (rt_i == '0);
              acc    <= {{WIDTH{1'b0}}, (op_div ? rs_mag : rt_mag)};
              opnd   <= op_div ? rt_mag : rs_mag;
              cnt    <= '0;
              busy_o <= 1'b1;
              state  <= CALC;
            end
          end
          CALC: begin
            acc <= acc_nxt;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              cnt   <= '0;
              state <= FIX;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          FIX: begin
            hi_o       <= fix_hi;
            lo_o       <= fix_lo;
            done_o     <= 1'b1;
            div_zero_o <= dz;
            busy_o     <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
